instr_mem_sync: RTL and testbench

//  Synchronous, parametrised instruction memory for the LEGv8 core. Replaces the fixed

---
 rtl/instr_mem_sync.sv | 150 +++++++++++++++
 tb/tb_instr_mem_sync.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_sync.sv
// Synchronous instruction memory for the LEGv8 fetch path: request/response
// handshake with configurable read latency, program-load write port and
// alignment/range fault detection.
module instr_mem_sync #(
  parameter int unsigned MEM_WORDS  = 64,
  parameter int unsigned RD_LATENCY = 2,
  parameter logic [31:0] FAULT_WORD = 32'hD503201F,
  parameter string       INIT_FILE  = ""
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [63:0] Address,
  output logic        RespValid,
  output logic [31:0] Data,
  output logic        Fault,
  input  logic        LoadEn,
  input  logic [63:0] LoadAddr,
  input  logic [31:0] LoadData,
  output logic        LoadErr
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((RD_LATENCY >= 2) ? (RD_LATENCY - 2) : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  logic [31:0] mem_q [MEM_WORDS];

  state_e           state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [31:0]      rd_word_q,    rd_word_d;
  logic             rd_fault_q,   rd_fault_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      data_q,       data_d;
  logic             fault_q,      fault_d;
  logic             load_err_q,   load_err_d;

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] ld_idx;
  logic             rd_bad;
  logic             ld_bad;
  logic             accept_c;

  // Power-on image: every word set to the fault NOP
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem_q[i] = FAULT_WORD;
    end
  end

  // Word index and fault decode; out of range means any bit above the index field is set
  always_comb begin
    rd_idx   = Address[IDX_W+1:2];
    ld_idx   = LoadAddr[IDX_W+1:2];
    rd_bad   = (Address[1:0] != 2'b00) || (Address[63:IDX_W+2] != '0);
    ld_bad   = (LoadAddr[1:0] != 2'b00) || (LoadAddr[63:IDX_W+2] != '0);
    accept_c = ReqValid && ReqReady;
  end

  // Next-state, read capture and registered response outputs
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_word_d    = rd_word_q;
    rd_fault_d   = rd_fault_q;
    resp_valid_d = 1'b0;
    data_d       = data_q;
    fault_d      = fault_q;
    load_err_d   = LoadEn && ld_bad;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          rd_word_d  = rd_bad ? FAULT_WORD : mem_q[rd_idx];
          rd_fault_d = rd_bad;
          if (RD_LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Data/Fault only move when the response cycle is entered
    if (state_d == S_RESP) begin
      resp_valid_d = 1'b1;
      data_d       = rd_word_d;
      fault_d      = rd_fault_d;
    end
  end

  // Control and output registers; reset drops any in-flight request
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rd_word_q    <= '0;
      rd_fault_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      data_q       <= '0;
      fault_q      <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_word_q    <= rd_word_d;
      rd_fault_q   <= rd_fault_d;
      resp_valid_q <= resp_valid_d;
      data_q       <= data_d;
      fault_q      <= fault_d;
      load_err_q   <= load_err_d;
    end
  end

  // Program-load write; the read above samples the pre-write word on the same edge
  always_ff @(posedge CLK) begin
    if (!Reset && LoadEn && !ld_bad) begin
      mem_q[ld_idx] <= LoadData;
    end
  end

  assign ReqReady  = (state_q == S_IDLE) && !Reset;
  assign RespValid = resp_valid_q;
  assign Data      = data_q;
  assign Fault     = fault_q;
  assign LoadErr   = load_err_q;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed self-checking bench for instr_mem_sync (latency 2 and latency 1 instances).
module tb_instr_mem_sync;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        ReqValid;
  logic [63:0] Address;
  logic        LoadEn;
  logic [63:0] LoadAddr;
  logic [31:0] LoadData;

  logic        ReqReady_a, RespValid_a, Fault_a, LoadErr_a;
  logic [31:0] Data_a;
  logic        ReqReady_b, RespValid_b, Fault_b, LoadErr_b;
  logic [31:0] Data_b;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] NOP = 32'hD503201F;

  instr_mem_sync #(.MEM_WORDS(64), .RD_LATENCY(2)) dut_a (
    .CLK(CLK), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady_a),
    .Address(Address), .RespValid(RespValid_a), .Data(Data_a), .Fault(Fault_a),
    .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData), .LoadErr(LoadErr_a)
  );

  instr_mem_sync #(.MEM_WORDS(64), .RD_LATENCY(1)) dut_b (
    .CLK(CLK), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady_b),
    .Address(Address), .RespValid(RespValid_b), .Data(Data_b), .Fault(Fault_b),
    .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData), .LoadErr(LoadErr_b)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [63:0] a, input logic [31:0] d);
    LoadEn = 1'b1; LoadAddr = a; LoadData = d;
    tick();
    LoadEn = 1'b0;
  endtask

  // Full request on the latency-2 instance starting from IDLE
  task automatic req_a(input string tag, input logic [63:0] a, input logic [31:0] exp_d,
                       input logic exp_f);
    ReqValid = 1'b1; Address = a;
    chk({tag, "_ready"}, 64'(ReqReady_a), 64'd1);
    tick();
    ReqValid = 1'b0;
    chk({tag, "_k1_valid"}, 64'(RespValid_a), 64'd0);
    chk({tag, "_k1_ready"}, 64'(ReqReady_a), 64'd0);
    tick();
    chk({tag, "_k2_valid"}, 64'(RespValid_a), 64'd1);
    chk({tag, "_data"}, 64'(Data_a), 64'(exp_d));
    chk({tag, "_fault"}, 64'(Fault_a), 64'(exp_f));
    tick();
    chk({tag, "_k3_valid"}, 64'(RespValid_a), 64'd0);
    chk({tag, "_hold"}, 64'(Data_a), 64'(exp_d));
  endtask

  logic [31:0] exp_seq [4];

  initial begin
    Reset = 1'b1; ReqValid = 1'b0; Address = '0;
    LoadEn = 1'b0; LoadAddr = '0; LoadData = '0;
    tick(); tick();
    chk("rst_ready", 64'(ReqReady_a), 64'd0);
    chk("rst_valid", 64'(RespValid_a), 64'd0);
    chk("rst_data", 64'(Data_a), 64'd0);
    chk("rst_fault", 64'(Fault_a), 64'd0);
    chk("rst_loaderr", 64'(LoadErr_a), 64'd0);
    Reset = 1'b0;
    #1;
    chk("post_rst_ready", 64'(ReqReady_a), 64'd1);

    // T1: program load then latency-2 read
    load(64'h000, 32'h910003E1);
    load(64'h004, 32'h910007E2);
    load(64'h008, 32'h8B020022);
    chk("load_ok_err", 64'(LoadErr_a), 64'd0);
    req_a("t1_rd4", 64'h004, 32'h910007E2, 1'b0);

    // T2: misaligned, out of range, and unwritten word
    req_a("t2_mis", 64'h006, NOP, 1'b1);
    req_a("t2_oor", 64'h100, NOP, 1'b1);
    req_a("t2_unw", 64'h00C, NOP, 1'b0);

    // T3: rejected loads (0x100 and 0x002 would alias word 0)
    load(64'h100, 32'hDEADBEEF);
    chk("t3_err_pulse", 64'(LoadErr_a), 64'd1);
    tick();
    chk("t3_err_clear", 64'(LoadErr_a), 64'd0);
    load(64'h002, 32'hCAFEF00D);
    chk("t3_mis_err", 64'(LoadErr_a), 64'd1);
    req_a("t3_rd0", 64'h000, 32'h910003E1, 1'b0);

    // T4: same-edge load and read of word 0x008 returns the old contents
    LoadEn = 1'b1; LoadAddr = 64'h008; LoadData = 32'h8B020021;
    ReqValid = 1'b1; Address = 64'h008;
    tick();
    LoadEn = 1'b0; ReqValid = 1'b0;
    chk("t4_k1_valid", 64'(RespValid_a), 64'd0);
    tick();
    chk("t4_k2_valid", 64'(RespValid_a), 64'd1);
    chk("t4_old", 64'(Data_a), 64'h8B020022);
    tick();
    req_a("t4_new", 64'h008, 32'h8B020021, 1'b0);

    // T5: back-to-back with ReqValid held, latency 2 -> accept every 3 cycles
    load(64'h00C, 32'h8B030063);
    exp_seq[0] = 32'h910003E1; exp_seq[1] = 32'h910007E2;
    exp_seq[2] = 32'h8B020021; exp_seq[3] = 32'h8B030063;
    tick(); tick();
    ReqValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Address = 64'(4 * i);
      chk($sformatf("t5a_ready_%0d", i), 64'(ReqReady_a), 64'd1);
      tick();
      chk($sformatf("t5a_wait_ready_%0d", i), 64'(ReqReady_a), 64'd0);
      chk($sformatf("t5a_wait_valid_%0d", i), 64'(RespValid_a), 64'd0);
      tick();
      chk($sformatf("t5a_resp_valid_%0d", i), 64'(RespValid_a), 64'd1);
      chk($sformatf("t5a_resp_ready_%0d", i), 64'(ReqReady_a), 64'd0);
      chk($sformatf("t5a_data_%0d", i), 64'(Data_a), 64'(exp_seq[i]));
      tick();
    end
    ReqValid = 1'b0;
    tick(); tick(); tick();

    // T5 with latency 1 -> accept every 2 cycles
    ReqValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Address = 64'(4 * i);
      chk($sformatf("t5b_ready_%0d", i), 64'(ReqReady_b), 64'd1);
      tick();
      chk($sformatf("t5b_resp_valid_%0d", i), 64'(RespValid_b), 64'd1);
      chk($sformatf("t5b_resp_ready_%0d", i), 64'(ReqReady_b), 64'd0);
      chk($sformatf("t5b_data_%0d", i), 64'(Data_b), 64'(exp_seq[i]));
      chk($sformatf("t5b_fault_%0d", i), 64'(Fault_b), 64'd0);
      tick();
    end
    ReqValid = 1'b0;
    tick(); tick(); tick();

    // T6: reset while in WAIT drops the request
    req_a("t6_pre", 64'h006, NOP, 1'b1);
    ReqValid = 1'b1; Address = 64'h000;
    tick();
    ReqValid = 1'b0;
    Reset = 1'b1;
    #1;
    chk("t6_rst_ready", 64'(ReqReady_a), 64'd0);
    tick();
    Reset = 1'b0;
    #1;
    chk("t6_valid", 64'(RespValid_a), 64'd0);
    chk("t6_data", 64'(Data_a), 64'd0);
    chk("t6_fault", 64'(Fault_a), 64'd0);
    chk("t6_ready", 64'(ReqReady_a), 64'd1);
    tick();
    chk("t6_no_late_resp", 64'(RespValid_a), 64'd0);
    req_a("t6_mem0", 64'h000, 32'h910003E1, 1'b0);
    req_a("t6_mem4", 64'h004, 32'h910007E2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
